// File: rtl/dsp_mem_pkg.sv
// Shared types and defaults for the stream-to-memory writer family.
package dsp_mem_pkg;

  typedef enum logic [1:0] {
    MW_IDLE,
    MW_RUN,
    MW_DONE
  } mw_state_t;

  localparam int unsigned MW_DATA_WIDTH_DEF = 32;
  localparam int unsigned MW_ADDR_WIDTH_DEF = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_writer.sv
// Buffers an input stream and writes it to consecutive memory words.
// Optional MEM_WRITER_STALL_CNT_EN adds a saturating write-stall counter.
module mem_writer
  import dsp_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MW_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = MW_ADDR_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done
`ifdef MEM_WRITER_STALL_CNT_EN
  ,output logic [15:0]          stall_cnt
`endif
);

  mw_state_t             state;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0] acc_cnt;
  logic [ADDR_WIDTH-1:0] ret_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push;
  logic                  pop;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign in_ready  = (state == MW_RUN) && !fifo_full && (acc_cnt < count_r);
  assign mem_req   = (state == MW_RUN) && !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = mem_req && mem_ack;
  assign mem_addr  = base_r + ret_cnt;
  // Storage is not reset, so the head is masked until a request is live.
  assign mem_wdata = mem_req ? fifo_head : '0;
  assign busy      = (state != MW_IDLE);
  assign done      = (state == MW_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= MW_IDLE;
      base_r  <= '0;
      count_r <= '0;
      acc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      case (state)
        MW_IDLE: begin
          if (start) begin
            base_r  <= base_addr;
            count_r <= word_count;
            acc_cnt <= '0;
            ret_cnt <= '0;
            state   <= (word_count != '0) ? MW_RUN : MW_DONE;
          end
        end
        MW_RUN: begin
          if (push) acc_cnt <= acc_cnt + 1'b1;
          if (pop) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == count_r - 1'b1) state <= MW_DONE;
          end
        end
        MW_DONE: state <= MW_IDLE;
        default: state <= MW_IDLE;
      endcase
    end
  end

`ifdef MEM_WRITER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == MW_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == MW_RUN && mem_req && !mem_ack && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Randomized self-checking bench for mem_writer against a queue-based write model.
module tb_mem_writer;

  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
`ifdef MEM_WRITER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_writer #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done)
`ifdef MEM_WRITER_STALL_CNT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  // Transfer engine: the model is a queue of buffered words plus accepted/retired totals.
  task automatic do_transfer(input logic [15:0] base, input logic [15:0] cnt,
                             input int ack_pct, input int ack_hold, input int valid_pct,
                             input logic [31:0] dseq, input bit seq_data,
                             input int abort_after, input bit poke_start);
    logic [31:0] q[$];
    int acc = 0, ret = 0, stall = 0, cyc = 0;
    bit running, done_exp, was_done, finished = 0;
    bit exp_ir, exp_mr;
    logic [15:0] exp_addr;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = cnt; in_valid = 1'b0; mem_ack = 1'b0;
    running  = (cnt != 16'd0);
    done_exp = (cnt == 16'd0);
    while (!finished) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      exp_ir = running && (q.size() < FD) && (acc < int'(cnt));
      exp_mr = running && (q.size() != 0);
      vectors++;
      if (in_ready !== exp_ir) begin
        miscompares++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir);
      end
      vectors++;
      if (mem_req !== exp_mr) begin
        miscompares++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_mr);
      end
      vectors++;
      if (busy !== (running || done_exp)) begin
        miscompares++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, running || done_exp);
      end
      vectors++;
      if (done !== done_exp) begin
        miscompares++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, done_exp);
      end
      if (exp_mr) begin
        exp_addr = base + 16'(ret);
        vectors++;
        if (mem_addr !== exp_addr) begin
          miscompares++; $display("FAIL mem_addr word=%0d got=%h exp=%h", ret, mem_addr, exp_addr);
        end
        vectors++;
        if (mem_wdata !== q[0]) begin
          miscompares++; $display("FAIL mem_wdata word=%0d got=%h exp=%h", ret, mem_wdata, q[0]);
        end
      end
      if (abort_after > 0 && ret == abort_after) begin
        in_valid = 1'b0; mem_ack = 1'b0;
        return;
      end
      if (cyc > 3000) begin
        miscompares++; $display("FAIL timeout base=%h cnt=%0d got=%0d_retired exp=%0d", base, cnt, ret, cnt);
        in_valid = 1'b0; mem_ack = 1'b0;
        return;
      end
      in_valid = ($urandom % 100) < valid_pct;
      in_data  = seq_data ? dseq + 32'(acc) : $urandom;
      mem_ack  = (cyc <= ack_hold) ? 1'b0 : (($urandom % 100) < ack_pct);
      if (poke_start && cyc == 3) begin
        start = 1'b1; base_addr = ~base; word_count = 16'd5;
      end
      was_done = done_exp;
      done_exp = 1'b0;
      if (exp_mr && mem_ack) begin
        void'(q.pop_front());
        ret++;
        if (ret == int'(cnt)) begin
          running = 1'b0; done_exp = 1'b1;
        end
      end else if (exp_mr) begin
        stall++;
      end
      if (in_valid && exp_ir) begin
        q.push_back(in_data);
        acc++;
      end
      if (was_done) finished = 1'b1;
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_done got=%b%b exp=00", busy, done);
    end
`ifdef MEM_WRITER_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'(stall)) begin
      miscompares++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, stall);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base_addr = 16'h1234; word_count = 16'd3;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    vectors++;
    if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    vectors++;
    if (mem_addr !== 16'h0) begin miscompares++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    vectors++;
    if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_transfer(16'h0100, 16'd4, 100, 0, 100, 32'hA0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_transfer(16'h0400, 16'd20, 100, 30, 100, $urandom, 1'b1, 0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    do_transfer(16'hFFFE, 16'd4, 70, 0, 80, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_count();
    do_transfer(16'h0777, 16'd0, 100, 0, 100, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_abort();
    do_transfer(16'h0300, 16'd8, 100, 0, 100, 32'h55, 1'b1, 3, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0) begin miscompares++; $display("FAIL abort_mem_req got=%b exp=0", mem_req); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", done); end
    end
    do_transfer(16'h0200, 16'd2, 100, 0, 100, 32'h77, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_transfer(16'h0010, 16'd4, 100, 6, 100, 32'h10, 1'b1, 0, 1'b0);
`ifdef MEM_WRITER_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL stall_five got=%0d exp=5", stall_cnt); end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      do_transfer(16'($urandom), 16'($urandom_range(1, 40)), int'($urandom_range(30, 100)),
                  int'($urandom_range(0, 10)), int'($urandom_range(30, 100)), 32'h0, 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    do_transfer(16'h0800, 16'd17, 100, 0, 100, 32'h0, 1'b0, 0, 1'b0);
    do_transfer(16'h0811, 16'd3, 50, 0, 50, 32'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_addr_wrap();
    test_zero_count();
    test_abort();
    test_stall();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
